// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional feature macro used by the top: WB_BYPASS_EN (read-port forwarding).
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_CLEAR = 1'b1
    } wb_state_e;

    // Cyclic increment of an index in 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// found by searching cyclically upward from rr_ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int idx_s;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx_s       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx_s]) begin
                grant        = '0;
                grant[idx_s] = 1'b1;
                grant_idx    = IDX_W'(idx_s);
                grant_valid  = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin sharing of the single write
// port among NUM_REQ writeback sources, with a registered output stage and a
// sequenced x1..x31 clear sweep.
// Optional macro WB_BYPASS_EN adds two combinational read-forwarding ports.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*5-1:0]        req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        clear_req,
    output logic                        clear_busy,
    output logic [WIDTH-1:0]            rf_write_data,
    output logic [4:0]                  rf_write_addr,
    output logic                        rf_en
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]                  rd_addr_a,
    input  logic [4:0]                  rd_addr_b,
    input  logic [WIDTH-1:0]            rd_data_a_in,
    input  logic [WIDTH-1:0]            rd_data_b_in,
    output logic [WIDTH-1:0]            rd_data_a,
    output logic [WIDTH-1:0]            rd_data_b
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_state_e              state_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [REG_ADDR_W-1:0]  sweep_cnt_r;

    logic [NUM_REQ-1:0]     grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   grant_valid_s;
    logic                   accept_s;
    logic [REG_ADDR_W-1:0]  sel_addr_s;
    logic [WIDTH-1:0]       sel_data_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Grants are only issued in idle, out of reset, and when no clear is starting.
    always_comb begin
        if (rst && (state_r == WB_IDLE) && !clear_req) begin
            accept_s = grant_valid_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign req_ready = accept_s ? grant_s : '0;

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s = sel_addr_s | ({REG_ADDR_W{grant_s[i]}} & req_addr[i*5 +: 5]);
            sel_data_s = sel_data_s | ({WIDTH{grant_s[i]}} & req_data[i*WIDTH +: WIDTH]);
        end
    end

    // Write FSM: output register, round-robin pointer and clear sweep counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= WB_IDLE;
            rr_ptr_r      <= '0;
            sweep_cnt_r   <= '0;
            clear_busy    <= 1'b0;
            rf_en         <= 1'b0;
            rf_write_addr <= 5'd0;
            rf_write_data <= '0;
        end else begin
            case (state_r)
                WB_IDLE: begin
                    if (clear_req) begin
                        state_r     <= WB_CLEAR;
                        sweep_cnt_r <= 5'd1;
                        clear_busy  <= 1'b1;
                        rf_en       <= 1'b0;
                    end else if (accept_s) begin
                        // x0 writes are consumed but never reach the register file.
                        rf_en         <= (sel_addr_s != 5'd0);
                        rf_write_addr <= sel_addr_s;
                        rf_write_data <= sel_data_s;
                        rr_ptr_r      <= IDX_W'(wrap_inc(int'(grant_idx_s), NUM_REQ));
                    end else begin
                        rf_en <= 1'b0;
                    end
                end
                WB_CLEAR: begin
                    rf_en         <= 1'b1;
                    rf_write_addr <= sweep_cnt_r;
                    rf_write_data <= '0;
                    if (sweep_cnt_r == 5'd31) begin
                        state_r     <= WB_IDLE;
                        clear_busy  <= 1'b0;
                        sweep_cnt_r <= 5'd0;
                    end else begin
                        sweep_cnt_r <= sweep_cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_r    <= WB_IDLE;
                    clear_busy <= 1'b0;
                    rf_en      <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to read port a when addresses match (never x0).
    always_comb begin
        if (rf_en && (rf_write_addr == rd_addr_a) && (rd_addr_a != 5'd0)) begin
            rd_data_a = rf_write_data;
        end else begin
            rd_data_a = rd_data_a_in;
        end
    end

    // Forward the in-flight write to read port b when addresses match (never x0).
    always_comb begin
        if (rf_en && (rf_write_addr == rd_addr_b) && (rd_addr_b != 5'd0)) begin
            rd_data_b = rf_write_data;
        end else begin
            rd_data_b = rd_data_b_in;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NUM_REQ=3, WIDTH=32).
// Forwarding checks are included when WB_BYPASS_EN is defined.
module tb_rf_write_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 3;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*5-1:0]     req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     clear_req;
    logic                     clear_busy;
    logic [WIDTH-1:0]         rf_write_data;
    logic [4:0]               rf_write_addr;
    logic                     rf_en;
`ifdef WB_BYPASS_EN
    logic [4:0]               rd_addr_a;
    logic [4:0]               rd_addr_b;
    logic [WIDTH-1:0]         rd_data_a_in;
    logic [WIDTH-1:0]         rd_data_b_in;
    logic [WIDTH-1:0]         rd_data_a;
    logic [WIDTH-1:0]         rd_data_b;
`endif

    int checks;
    int errors;

    rf_write_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .clear_req     (clear_req),
        .clear_busy    (clear_busy),
        .rf_write_data (rf_write_data),
        .rf_write_addr (rf_write_addr),
        .rf_en         (rf_en)
`ifdef WB_BYPASS_EN
        ,
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a_in  (rd_data_a_in),
        .rd_data_b_in  (rd_data_b_in),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]         = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        clear_req = 1'b0;
`ifdef WB_BYPASS_EN
        rd_addr_a    = 5'd0;
        rd_addr_b    = 5'd0;
        rd_data_a_in = 32'd0;
        rd_data_b_in = 32'd0;
`endif
        #2;
        // Reset values, ready suppressed while reset is held.
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rf_en", 32'(rf_en), 32'd0);
        check("rst_addr", 32'(rf_write_addr), 32'd0);
        check("rst_data", rf_write_data, 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        req_valid = 3'b000;
        tick();
        rst = 1'b1;
        tick();

        // Test 1: single request from requester 0.
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        check("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 3'b000;
        check("t1_rf_en", 32'(rf_en), 32'd1);
        check("t1_addr", 32'(rf_write_addr), 32'd5);
        check("t1_data", rf_write_data, 32'hDEADBEEF);
        tick();
        check("t1_rf_en_drop", 32'(rf_en), 32'd0);
        check("t1_addr_hold", 32'(rf_write_addr), 32'd5);

        // Test 2: all three valid from rr_ptr=0, expect 0,1,2,0,1,2.
        do_reset();
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h101);
        set_req(2, 5'd3, 32'h102);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t2_ready", 32'(req_ready), 32'd1 << (k % 3));
            tick();
            check("t2_rf_en", 32'(rf_en), 32'd1);
            check("t2_addr", 32'(rf_write_addr), 32'((k % 3) + 1));
            check("t2_data", rf_write_data, 32'h100 + 32'(k % 3));
        end
        req_valid = 3'b000;
        tick();

        // Test 3: write to x0 from requester 1 is consumed, rf_en stays low.
        set_req(1, 5'd0, 32'hAA);
        req_valid = 3'b010;
        #1;
        check("t3_ready", 32'(req_ready), 32'd2);
        tick();
        check("t3_rf_en", 32'(rf_en), 32'd0);
        check("t3_data", rf_write_data, 32'hAA);
        // Pointer moved to 2: with all valid, requester 2 wins.
        set_req(2, 5'd9, 32'h99);
        req_valid = 3'b111;
        #1;
        check("t3_ptr_adv", 32'(req_ready), 32'd4);
        tick();
        req_valid = 3'b000;
        check("t3_addr9", 32'(rf_write_addr), 32'd9);
        check("t3_en9", 32'(rf_en), 32'd1);

        // Test 4: clear takes priority over requests 0 and 1.
        set_req(0, 5'd11, 32'h1111);
        set_req(1, 5'd12, 32'h2222);
        req_valid = 3'b011;
        clear_req = 1'b1;
        #1;
        check("t4_no_grant", 32'(req_ready), 32'd0);
        tick();
        clear_req = 1'b0;
        check("t4_busy0", 32'(clear_busy), 32'd1);
        check("t4_en0", 32'(rf_en), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            // A second clear pulse mid-sweep must be ignored.
            clear_req = (k == 5) ? 1'b1 : 1'b0;
            #1;
            check("t4_ready_sweep", 32'(req_ready), 32'd0);
            tick();
            clear_req = 1'b0;
            check("t4_en", 32'(rf_en), 32'd1);
            check("t4_addr", 32'(rf_write_addr), 32'(k));
            check("t4_data", rf_write_data, 32'd0);
            check("t4_busy", 32'(clear_busy), (k < 31) ? 32'd1 : 32'd0);
        end
        #1;
        check("t4_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 3'b000;
        check("t4_post_addr", 32'(rf_write_addr), 32'd11);
        check("t4_post_data", rf_write_data, 32'h1111);
        tick();

        // Test 5: reset asserted at sweep address 10.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        check("t5_at10", 32'(rf_write_addr), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rf_en", 32'(rf_en), 32'd0);
        check("t5_addr", 32'(rf_write_addr), 32'd0);
        check("t5_data", rf_write_data, 32'd0);
        check("t5_busy", 32'(clear_busy), 32'd0);
        #2;
        rst = 1'b1;
        req_valid = 3'b011;
        #1;
        check("t5_idle_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 3'b000;
        check("t5_idle_en", 32'(rf_en), 32'd1);
        check("t5_idle_busy", 32'(clear_busy), 32'd0);
        tick();

`ifdef WB_BYPASS_EN
        // Test 6: forwarding on x7, none on x0.
        set_req(0, 5'd7, 32'h1234);
        req_valid    = 3'b001;
        rd_addr_a    = 5'd7;
        rd_data_a_in = 32'd0;
        rd_addr_b    = 5'd3;
        rd_data_b_in = 32'h55;
        tick();
        req_valid = 3'b000;
        #1;
        check("t6_fwd_a", rd_data_a, 32'h1234);
        check("t6_nofwd_b", rd_data_b, 32'h55);
        tick();
        check("t6_idle_a", rd_data_a, 32'd0);
        set_req(0, 5'd0, 32'h9999);
        req_valid    = 3'b001;
        rd_addr_a    = 5'd0;
        rd_data_a_in = 32'h77;
        tick();
        req_valid = 3'b000;
        #1;
        check("t6_x0_a", rd_data_a, 32'h77);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
